// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Zero-latency grant with data priority, bounded fetch starvation, one-cycle read return.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             grant_if;
    logic             grant_d;

    // Arbitration, owner next-state and fetch starvation counter
    always_comb begin
        grant_if      = 1'b0;
        grant_d       = 1'b0;
        state_next    = IDLE;
        wait_cnt_next = wait_cnt;

        if (!reset) begin
            if (if_req && d_req) begin
                if (wait_cnt < WAIT_LIM) grant_d  = 1'b1;
                else                     grant_if = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end

        if (grant_if)              state_next = OWN_IF;
        else if (grant_d && !d_we) state_next = OWN_D;

        if (!if_req || grant_if)     wait_cnt_next = '0;
        else if (wait_cnt < WAIT_LIM) wait_cnt_next = wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Read data capture; the non-selected register keeps its last value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant_if)         if_rdata <= mem_rdata;
            if (grant_d && !d_we) d_rdata  <= mem_rdata;
        end
    end

    // Owner state of the previous cycle doubles as the read-response valid
    assign if_rvalid = (state == OWN_IF);
    assign d_rvalid  = (state == OWN_D);

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign stall_if  = if_req && !grant_if;
    assign stall_mem = d_req && !grant_d;

    assign mem_addr  = grant_d ? d_addr : if_addr;
    assign mem_we    = grant_d && d_we;
    assign mem_wdata = d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_WAIT=3).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_mem;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .stall_mem(stall_mem),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #2;
        // Reset state
        chk("rst_if_rvalid", if_rvalid === 1'b0);
        chk("rst_d_rvalid",  d_rvalid  === 1'b0);
        chk("rst_if_rdata",  if_rdata  === 32'd0);
        chk("rst_d_rdata",   d_rdata   === 32'd0);
        chk("rst_wait_cnt",  dut.wait_cnt === 4'd0);
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        #1;
        chk("rst_if_gnt",    if_gnt    === 1'b0);
        chk("rst_d_gnt",     d_gnt     === 1'b0);
        chk("rst_mem_we",    mem_we    === 1'b0);
        chk("rst_stall_if",  stall_if  === 1'b1);
        chk("rst_stall_mem", stall_mem === 1'b1);
        cyc();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;

        // Fetch only, three back-to-back grants
        cyc();
        if_req = 1'b1; if_addr = 32'h8; mem_rdata = 32'd36;
        #1;
        chk("f0_if_gnt",    if_gnt    === 1'b1);
        chk("f0_stall_if",  stall_if  === 1'b0);
        chk("f0_mem_addr",  mem_addr  === 32'h8);
        chk("f0_mem_we",    mem_we    === 1'b0);
        chk("f0_if_rvalid", if_rvalid === 1'b0);
        for (int i = 1; i < 3; i++) begin
            cyc(); #1;
            chk("f_if_gnt",    if_gnt    === 1'b1);
            chk("f_if_rvalid", if_rvalid === 1'b1);
            chk("f_if_rdata",  if_rdata  === 32'd36);
            chk("f_stall_if",  stall_if  === 1'b0);
        end
        cyc();
        if_req = 1'b0;
        #1;
        chk("f3_if_gnt",    if_gnt    === 1'b0);
        chk("f3_if_rvalid", if_rvalid === 1'b1);
        cyc(); #1;
        chk("f4_if_rvalid", if_rvalid === 1'b0);

        // Load vs fetch contention
        cyc();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h28; mem_rdata = 32'd100;
        #1;
        chk("c0_d_gnt",     d_gnt     === 1'b1);
        chk("c0_if_gnt",    if_gnt    === 1'b0);
        chk("c0_stall_if",  stall_if  === 1'b1);
        chk("c0_stall_mem", stall_mem === 1'b0);
        chk("c0_mem_addr",  mem_addr  === 32'h28);
        cyc();
        d_req = 1'b0; mem_rdata = 32'h55;
        #1;
        chk("c1_d_rvalid",  d_rvalid  === 1'b1);
        chk("c1_d_rdata",   d_rdata   === 32'd100);
        chk("c1_if_gnt",    if_gnt    === 1'b1);
        chk("c1_mem_addr",  mem_addr  === 32'h8);
        cyc();
        if_req = 1'b0;
        #1;
        chk("c2_if_rvalid", if_rvalid === 1'b1);
        chk("c2_if_rdata",  if_rdata  === 32'h55);
        chk("c2_d_rvalid",  d_rvalid  === 1'b0);
        chk("c2_d_rdata",   d_rdata   === 32'd100);

        // Starvation override: fetch wins in cycles 3 and 7
        for (int i = 0; i < 8; i++) begin
            cyc();
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_rdata = 32'(i + 16);
            #1;
            chk("s_if_gnt",    if_gnt    === 1'((i == 3) || (i == 7)));
            chk("s_d_gnt",     d_gnt     === 1'(!((i == 3) || (i == 7))));
            chk("s_stall_mem", stall_mem === 1'((i == 3) || (i == 7)));
            chk("s_wait_cnt",  dut.wait_cnt === 4'(i % 4));
            if (i == 4) begin
                chk("s4_if_rvalid", if_rvalid === 1'b1);
                chk("s4_if_rdata",  if_rdata  === 32'h13);
                chk("s4_d_rvalid",  d_rvalid  === 1'b0);
                chk("s4_d_rdata",   d_rdata   === 32'h12);
            end
        end
        cyc();
        if_req = 1'b0; d_req = 1'b0;

        // Store completes in grant cycle, no response
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'd19;
        #1;
        chk("st_d_gnt",     d_gnt     === 1'b1);
        chk("st_mem_we",    mem_we    === 1'b1);
        chk("st_mem_addr",  mem_addr  === 32'h4);
        chk("st_mem_wdata", mem_wdata === 32'd19);
        cyc();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("st1_d_rvalid", d_rvalid  === 1'b0);
        chk("st1_mem_we",   mem_we    === 1'b0);

        // Reset mid-read
        cyc();
        if_req = 1'b1; d_req = 1'b1; mem_rdata = 32'h66;
        cyc();
        d_req = 1'b0; mem_rdata = 32'h77;
        #1;
        chk("r_if_gnt",     if_gnt    === 1'b1);
        chk("r_wait_pre",   dut.wait_cnt === 4'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("r_if_rvalid",  if_rvalid === 1'b0);
        chk("r_if_rdata",   if_rdata  === 32'd0);
        chk("r_d_rdata",    d_rdata   === 32'd0);
        chk("r_wait_cnt",   dut.wait_cnt === 4'd0);
        chk("r_if_gnt_off", if_gnt    === 1'b0);
        chk("r_stall_if",   stall_if  === 1'b1);
        cyc();
        if_req = 1'b0;
        reset = 1'b0;
        cyc(); #1;
        chk("r1_if_rvalid", if_rvalid === 1'b0);
        chk("r1_d_rvalid",  d_rvalid  === 1'b0);

        // Idle for five cycles
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("i_mem_we",    mem_we    === 1'b0);
            chk("i_if_gnt",    if_gnt    === 1'b0);
            chk("i_d_gnt",     d_gnt     === 1'b0);
            chk("i_if_rvalid", if_rvalid === 1'b0);
            chk("i_d_rvalid",  d_rvalid  === 1'b0);
            chk("i_state",     dut.state === 2'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
